// File: rtl/braid_mix_scheduler.sv
// Run sequencer for an N-lane x D-stage mixer braid: LOAD, then MIX/XFER for each stage, with an abort-triggered FLUSH.
// Optional macro BRAID_SCHED_PAUSE_EN adds a pause input that freezes sequencing in LOAD/MIX/XFER.
module braid_mix_scheduler #(
  parameter int LANES        = 3,
  parameter int DEPTH        = 16,
  parameter int LOAD_CYCLES  = 4,
  parameter int MIX_CYCLES   = 8,
  parameter int XFER_CYCLES  = 2,
  parameter int FLUSH_CYCLES = 6,
  parameter int TW           = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
`ifdef BRAID_SCHED_PAUSE_EN
  input  logic                    pause,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [$clog2(DEPTH):0]  stage,
  output logic [LANES-1:0]        load_vlv,
  output logic [LANES-1:0]        mix_en,
  output logic [LANES-1:0]        xfer_vlv,
  output logic                    flush_vlv
);

  localparam int SW = $clog2(DEPTH) + 1;
  localparam logic [TW-1:0] LOAD_T  = TW'(LOAD_CYCLES - 1);
  localparam logic [TW-1:0] MIX_T   = TW'(MIX_CYCLES - 1);
  localparam logic [TW-1:0] XFER_T  = TW'(XFER_CYCLES - 1);
  localparam logic [TW-1:0] FLUSH_T = TW'(FLUSH_CYCLES - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MIX   = 3'd2,
    XFER  = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state_r, state_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic [SW-1:0]   stage_r, stage_s;
  logic            pause_s;
  logic            hold_s;

  logic            busy_r, done_r, err_r, flush_r;
  logic [LANES-1:0] load_r, mix_r, xfer_r;

`ifdef BRAID_SCHED_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // Pause only matters while a timed run state is active and no abort is pending
  assign hold_s = pause_s && !abort &&
                  ((state_r == LOAD) || (state_r == MIX) || (state_r == XFER));

  // Next-state, timer and stage sequencing
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    stage_s = stage_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LOAD;
          timer_s = LOAD_T;
          stage_s = {SW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      LOAD, MIX, XFER: begin
        if (abort) begin
          state_s = FLUSH;
          timer_s = FLUSH_T;
          stage_s = {SW{1'b0}};
        end else if (hold_s) begin
          state_s = state_r;
        end else if (timer_r != {TW{1'b0}}) begin
          timer_s = timer_r - TW'(1);
        end else if (state_r == LOAD) begin
          state_s = MIX;
          timer_s = MIX_T;
          stage_s = {SW{1'b0}};
        end else if (state_r == MIX) begin
          state_s = XFER;
          timer_s = XFER_T;
        end else if (stage_r == LAST_STAGE) begin
          state_s = DONE;
          timer_s = {TW{1'b0}};
        end else begin
          state_s = MIX;
          timer_s = MIX_T;
          stage_s = stage_r + SW'(1);
        end
      end
      FLUSH: begin
        if (timer_r != {TW{1'b0}}) begin
          timer_s = timer_r - TW'(1);
        end else begin
          state_s = IDLE;
          stage_s = {SW{1'b0}};
        end
      end
      DONE: begin
        state_s = IDLE;
        stage_s = {SW{1'b0}};
      end
      default: begin
        state_s = IDLE;
        timer_s = {TW{1'b0}};
        stage_s = {SW{1'b0}};
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      timer_r <= {TW{1'b0}};
      stage_r <= {SW{1'b0}};
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      stage_r <= stage_s;
    end
  end

  // Outputs decoded from the next state so each valve is active exactly in its state's cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      flush_r <= 1'b0;
      load_r  <= {LANES{1'b0}};
      mix_r   <= {LANES{1'b0}};
      xfer_r  <= {LANES{1'b0}};
    end else begin
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      err_r   <= start && (state_r != IDLE);
      flush_r <= (state_s == FLUSH);
      load_r  <= ((state_s == LOAD) && !hold_s) ? {LANES{1'b1}} : {LANES{1'b0}};
      mix_r   <= ((state_s == MIX)  && !hold_s) ? {LANES{1'b1}} : {LANES{1'b0}};
      xfer_r  <= ((state_s == XFER) && !hold_s) ? {LANES{1'b1}} : {LANES{1'b0}};
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign stage     = stage_r;
  assign load_vlv  = load_r;
  assign mix_en    = mix_r;
  assign xfer_vlv  = xfer_r;
  assign flush_vlv = flush_r;

endmodule

// File: tb/tb_braid_mix_scheduler.sv
// Scoreboard bench for braid_mix_scheduler: stimulus pushes expected output-change events,
// a negedge monitor pops and compares them whenever the DUT outputs change.
module tb_braid_mix_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pause = 1'b0;
  logic        busy, done, err, flush_vlv;
  logic [4:0]  stage;
  logic [2:0]  load_vlv, mix_en, xfer_vlv;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [16:0] vec;
  } ev_t;

  ev_t  exp_q[$];
  int   err_q[$];
  logic [16:0] prev_vec = 17'd0;

  braid_mix_scheduler dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
`ifdef BRAID_SCHED_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy),
    .done(done),
    .err(err),
    .stage(stage),
    .load_vlv(load_vlv),
    .mix_en(mix_en),
    .xfer_vlv(xfer_vlv),
    .flush_vlv(flush_vlv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] mk(bit b, bit d, int s, bit l, bit m, bit x, bit f);
    logic [4:0] s5;
    s5 = s[4:0];
    return {b, d, s5, {3{l}}, {3{m}}, {3{x}}, f};
  endfunction

  function automatic logic [16:0] obs();
    return {busy, done, stage, load_vlv, mix_en, xfer_vlv, flush_vlv};
  endfunction

  task automatic push(int c, logic [16:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  // Expected changes of a normal run started at t0, restricted to cycles below stop
  task automatic push_run(int t0, int stop);
    if (t0 + 1 < stop) push(t0 + 1, mk(1, 0, 0, 1, 0, 0, 0));
    for (int s = 0; s < 16; s++) begin
      if (t0 + 5 + 10 * s < stop)  push(t0 + 5 + 10 * s,  mk(1, 0, s, 0, 1, 0, 0));
      if (t0 + 13 + 10 * s < stop) push(t0 + 13 + 10 * s, mk(1, 0, s, 0, 0, 1, 0));
    end
    if (t0 + 165 < stop) push(t0 + 165, mk(1, 1, 15, 0, 0, 0, 0));
    if (t0 + 166 < stop) push(t0 + 166, 17'd0);
  endtask

  task automatic issue_start(int stop, output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    push_run(t0, stop);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  // Monitor: compare every output change against the next expected event
  always @(negedge clk) begin
    logic [16:0] cur;
    ev_t e;
    int ec;
    cur = obs();
    if (cur !== prev_vec) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL seq_unexpected cyc=%0d got=%h expected=no change", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.vec !== cur) begin
          fails++;
          $display("FAIL seq_event cyc=%0d got=%h expected=%h at cyc %0d", cyc, cur, e.vec, e.cyc);
        end
      end
      prev_vec = cur;
    end
    if (err === 1'b1) begin
      tests++;
      if (err_q.size() == 0) begin
        fails++;
        $display("FAIL err_unexpected cyc=%0d got=1 expected=0", cyc);
      end else begin
        ec = err_q.pop_front();
        if (ec != cyc) begin
          fails++;
          $display("FAIL err_pulse got cyc=%0d expected cyc=%0d", cyc, ec);
        end
      end
    end
  end

  initial begin
    int t0;
    #1 rst = 1'b1;
    #2 chk("reset_outputs", {15'd0, obs()}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full run with default timing
    issue_start(1000000, t0);
    wait_until(t0 + 170);

    // start during stage 3 XFER: err pulse, timing unchanged
    issue_start(1000000, t0);
    wait_until(t0 + 43);
    start = 1'b1;
    err_q.push_back(t0 + 44);
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 170);

    // abort during stage 5 MIX, second abort during FLUSH is ignored
    issue_start(t0 + 1000 + 58, t0);
    while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc >= t0 + 58) void'(exp_q.pop_back());
    wait_until(t0 + 57);
    abort = 1'b1;
    push(t0 + 58, mk(1, 0, 0, 0, 0, 0, 1));
    push(t0 + 64, 17'd0);
    @(negedge clk);
    abort = 1'b0;
    wait_until(t0 + 60);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_until(t0 + 70);

    // abort alone in IDLE: nothing happens
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);

    // start and abort together in IDLE -> LOAD, then abort in LOAD -> FLUSH
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    t0 = cyc;
    push(t0 + 1, mk(1, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    push(t0 + 3, mk(1, 0, 0, 0, 0, 0, 1));
    push(t0 + 9, 17'd0);
    @(negedge clk);
    abort = 1'b0;
    wait_until(t0 + 12);

    // async reset mid-MIX (stage 1), then a full run
    issue_start(0, t0);
    push_run(t0, t0 + 18);
    wait_until(t0 + 17);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {15'd0, obs()}, 32'd0);
    push(t0 + 18, 17'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue_start(1000000, t0);
    wait_until(t0 + 170);

    chk("events_left", exp_q.size(), 32'd0);
    chk("err_events_left", err_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
